// File: rtl/conv_bram_arb_pkg.sv
// -----------------------------------------------------------------------------
// conv_bram_arb_pkg
// Shared types and constants for the convolution-stage membrane-potential BRAM
// arbiter.
//   client_e  : port-A read clients (conv engine, pooling/readout stage)
//   wr_src_e  : port-B write source selected in a given cycle
//   STAT_W    : width of the optional saturating statistics counters
//   sat_inc() : saturating increment used by the statistics counters
// -----------------------------------------------------------------------------
package conv_bram_arb_pkg;

  typedef enum logic {
    CLIENT_CONV = 1'b0,
    CLIENT_POOL = 1'b1
  } client_e;

  typedef enum logic [1:0] {
    WR_NONE  = 2'd0,
    WR_CONV  = 2'd1,
    WR_CLEAR = 2'd2
  } wr_src_e;

  localparam int STAT_W = 16;

  // Counter sticks at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

endpackage : conv_bram_arb_pkg

// File: rtl/dp_bram_if.sv
// -----------------------------------------------------------------------------
// dp_bram_if
// Dual-port BRAM bundle. Port A and port B each have enable, write enable,
// address and write data; port A returns read data one cycle after an enabled
// read. Port B is used write-only by the arbiter, so it has no read data.
//   modport arbiter : drives clock, reset, both ports; receives data_out_a
//   modport bram    : the memory side of the same signals
// -----------------------------------------------------------------------------
interface dp_bram_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
);

  logic                  clk;
  logic                  rst_n;

  logic                  en_a;
  logic                  we_a;
  logic [ADDR_WIDTH-1:0] addr_a;
  logic [DATA_WIDTH-1:0] data_in_a;
  logic [DATA_WIDTH-1:0] data_out_a;

  logic                  en_b;
  logic                  we_b;
  logic [ADDR_WIDTH-1:0] addr_b;
  logic [DATA_WIDTH-1:0] data_in_b;

  modport arbiter (
    output clk, rst_n,
    output en_a, we_a, addr_a, data_in_a,
    input  data_out_a,
    output en_b, we_b, addr_b, data_in_b
  );

  modport bram (
    input  clk, rst_n,
    input  en_a, we_a, addr_a, data_in_a,
    output data_out_a,
    input  en_b, we_b, addr_b, data_in_b
  );

endinterface : dp_bram_if

// File: rtl/conv_bram_rr_arb2.sv
// -----------------------------------------------------------------------------
// conv_bram_rr_arb2
// Two-way round-robin arbiter. The grant is combinational in the request
// cycle; the priority pointer moves to the other client after every grant.
// The pointer resets to the conv client.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   req_i[1:0]: requests, bit 0 = conv, bit 1 = pool
//   gnt_o[1:0]: one-hot grant (or zero), same bit order
// -----------------------------------------------------------------------------
module conv_bram_rr_arb2
  import conv_bram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  client_e ptr_q, ptr_d;

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    gnt_o = 2'b00;
    ptr_d = ptr_q;

    if (req_i[0] && req_i[1]) begin
      gnt_o = (ptr_q == CLIENT_CONV) ? 2'b01 : 2'b10;
    end else begin
      gnt_o = req_i;
    end

    if (gnt_o[0]) begin
      ptr_d = CLIENT_POOL;
    end else if (gnt_o[1]) begin
      ptr_d = CLIENT_CONV;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= CLIENT_CONV;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule : conv_bram_rr_arb2

// File: rtl/conv_bram_arbiter.sv
// -----------------------------------------------------------------------------
// conv_bram_arbiter
// Owns the dual-port membrane-potential BRAM of the convolution stage.
//   Port A: read-only, round-robin between conv reads and pool reads.
//   Port B: write-only; pending pool clears (strict priority) or conv writes.
//   A port-A read that hits the address written on port B in the same cycle
//   returns the written data one cycle later (write-first forwarding).
// Ports:
//   clk, rst                       : clock, asynchronous active-high reset
//   conv_rd_req/addr -> gnt/valid/data : conv read channel
//   conv_wr_req/addr/data -> gnt   : conv write channel
//   pool_rd_req/addr -> gnt/valid/data : pool read-and-clear channel
//   stat_wr_stall, stat_fwd        : saturating statistics counters, present
//                                    only when CONV_BRAM_ARB_STATS_EN is defined
//   bram                           : dp_bram_if.arbiter
// Configuration macro: CONV_BRAM_ARB_STATS_EN
// -----------------------------------------------------------------------------
module conv_bram_arbiter
  import conv_bram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  conv_rd_req,
  input  logic [ADDR_WIDTH-1:0] conv_rd_addr,
  output logic                  conv_rd_gnt,
  output logic                  conv_rd_valid,
  output logic [DATA_WIDTH-1:0] conv_rd_data,

  input  logic                  conv_wr_req,
  input  logic [ADDR_WIDTH-1:0] conv_wr_addr,
  input  logic [DATA_WIDTH-1:0] conv_wr_data,
  output logic                  conv_wr_gnt,

  input  logic                  pool_rd_req,
  input  logic [ADDR_WIDTH-1:0] pool_rd_addr,
  output logic                  pool_rd_gnt,
  output logic                  pool_rd_valid,
  output logic [DATA_WIDTH-1:0] pool_rd_data,

`ifdef CONV_BRAM_ARB_STATS_EN
  output logic [STAT_W-1:0]     stat_wr_stall,
  output logic [STAT_W-1:0]     stat_fwd,
`endif

  dp_bram_if.arbiter            bram
);

  // ---------------------------------------------------------------------------
  // Port A: round-robin read arbitration
  // ---------------------------------------------------------------------------
  logic [1:0]            rd_req;
  logic [1:0]            rd_gnt;
  logic                  a_en;
  logic [ADDR_WIDTH-1:0] a_addr;

  // Requests are masked during reset so no grant is visible while rst is high.
  assign rd_req = {pool_rd_req, conv_rd_req} & {2{~rst}};

  conv_bram_rr_arb2 u_rr_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i (rd_req),
    .gnt_o (rd_gnt)
  );

  assign conv_rd_gnt = rd_gnt[0];
  assign pool_rd_gnt = rd_gnt[1];
  assign a_en        = |rd_gnt;
  assign a_addr      = rd_gnt[1] ? pool_rd_addr : conv_rd_addr;

  // ---------------------------------------------------------------------------
  // Clear generation: a pool grant schedules a zero write for the next cycle
  // ---------------------------------------------------------------------------
  logic                  clr_pend_q, clr_pend_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;

  assign clr_pend_d = rd_gnt[1];
  assign clr_addr_d = rd_gnt[1] ? pool_rd_addr : clr_addr_q;

  // ---------------------------------------------------------------------------
  // Port B: pending clear wins, otherwise a conv write goes straight through
  // ---------------------------------------------------------------------------
  wr_src_e               wr_src;
  logic                  b_en;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_data;

  always_comb begin
    wr_src = WR_NONE;
    b_en   = 1'b0;
    b_addr = '0;
    b_data = '0;

    if (clr_pend_q) begin
      wr_src = WR_CLEAR;
    end else if (conv_wr_req && !rst) begin
      wr_src = WR_CONV;
    end

    case (wr_src)
      WR_CLEAR: begin
        b_en   = 1'b1;
        b_addr = clr_addr_q;
        b_data = '0;
      end
      WR_CONV: begin
        b_en   = 1'b1;
        b_addr = conv_wr_addr;
        b_data = conv_wr_data;
      end
      default: ;
    endcase
  end

  assign conv_wr_gnt = (wr_src == WR_CONV);

  // ---------------------------------------------------------------------------
  // Write-first forwarding: the BRAM returns the old word on a same-address
  // read/write, so the written word is captured and substituted at t+1.
  // ---------------------------------------------------------------------------
  logic                  fwd_hit;
  logic                  fwd_q, fwd_d;
  logic [DATA_WIDTH-1:0] fwd_data_q, fwd_data_d;

  assign fwd_hit    = a_en && b_en && (a_addr == b_addr);
  assign fwd_d      = fwd_hit;
  assign fwd_data_d = fwd_hit ? b_data : fwd_data_q;

  // ---------------------------------------------------------------------------
  // Read return: valid is the registered grant; data is held when not valid
  // ---------------------------------------------------------------------------
  logic                  conv_vld_q, pool_vld_q;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] conv_hold_q, conv_hold_d;
  logic [DATA_WIDTH-1:0] pool_hold_q, pool_hold_d;

  assign rd_word = fwd_q ? fwd_data_q : bram.data_out_a;

  assign conv_rd_valid = conv_vld_q;
  assign pool_rd_valid = pool_vld_q;
  assign conv_rd_data  = conv_vld_q ? rd_word : conv_hold_q;
  assign pool_rd_data  = pool_vld_q ? rd_word : pool_hold_q;
  assign conv_hold_d   = conv_rd_data;
  assign pool_hold_d   = pool_rd_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_pend_q  <= 1'b0;
      clr_addr_q  <= '0;
      fwd_q       <= 1'b0;
      fwd_data_q  <= '0;
      conv_vld_q  <= 1'b0;
      pool_vld_q  <= 1'b0;
      conv_hold_q <= '0;
      pool_hold_q <= '0;
    end else begin
      clr_pend_q  <= clr_pend_d;
      clr_addr_q  <= clr_addr_d;
      fwd_q       <= fwd_d;
      fwd_data_q  <= fwd_data_d;
      conv_vld_q  <= rd_gnt[0];
      pool_vld_q  <= rd_gnt[1];
      conv_hold_q <= conv_hold_d;
      pool_hold_q <= pool_hold_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional statistics
  // ---------------------------------------------------------------------------
`ifdef CONV_BRAM_ARB_STATS_EN
  logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [STAT_W-1:0] fwd_cnt_q, fwd_cnt_d;

  assign stall_cnt_d = (conv_wr_req && !conv_wr_gnt) ? sat_inc(stall_cnt_q) : stall_cnt_q;
  assign fwd_cnt_d   = fwd_hit ? sat_inc(fwd_cnt_q) : fwd_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stat_wr_stall = stall_cnt_q;
  assign stat_fwd      = fwd_cnt_q;
`endif

  // ---------------------------------------------------------------------------
  // BRAM interface
  // ---------------------------------------------------------------------------
  assign bram.clk       = clk;
  assign bram.rst_n     = ~rst;
  assign bram.en_a      = a_en;
  assign bram.we_a      = 1'b0;
  assign bram.addr_a    = a_addr;
  assign bram.data_in_a = '0;
  assign bram.en_b      = b_en;
  assign bram.we_b      = b_en;
  assign bram.addr_b    = b_addr;
  assign bram.data_in_b = b_data;

endmodule : conv_bram_arbiter

// File: tb/tb_conv_bram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_conv_bram_arbiter
// Directed bench for conv_bram_arbiter with a behavioural dual-port BRAM
// (synchronous read, old data on same-address read/write).
// -----------------------------------------------------------------------------
module tb_conv_bram_arbiter;

  localparam int DW = 16;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;

  logic          conv_rd_req;
  logic [AW-1:0] conv_rd_addr;
  logic          conv_rd_gnt;
  logic          conv_rd_valid;
  logic [DW-1:0] conv_rd_data;
  logic          conv_wr_req;
  logic [AW-1:0] conv_wr_addr;
  logic [DW-1:0] conv_wr_data;
  logic          conv_wr_gnt;
  logic          pool_rd_req;
  logic [AW-1:0] pool_rd_addr;
  logic          pool_rd_gnt;
  logic          pool_rd_valid;
  logic [DW-1:0] pool_rd_data;
`ifdef CONV_BRAM_ARB_STATS_EN
  logic [15:0]   stat_wr_stall;
  logic [15:0]   stat_fwd;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dp_bram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bram_if ();

  conv_bram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .conv_rd_req   (conv_rd_req),
    .conv_rd_addr  (conv_rd_addr),
    .conv_rd_gnt   (conv_rd_gnt),
    .conv_rd_valid (conv_rd_valid),
    .conv_rd_data  (conv_rd_data),
    .conv_wr_req   (conv_wr_req),
    .conv_wr_addr  (conv_wr_addr),
    .conv_wr_data  (conv_wr_data),
    .conv_wr_gnt   (conv_wr_gnt),
    .pool_rd_req   (pool_rd_req),
    .pool_rd_addr  (pool_rd_addr),
    .pool_rd_gnt   (pool_rd_gnt),
    .pool_rd_valid (pool_rd_valid),
    .pool_rd_data  (pool_rd_data),
`ifdef CONV_BRAM_ARB_STATS_EN
    .stat_wr_stall (stat_wr_stall),
    .stat_fwd      (stat_fwd),
`endif
    .bram          (bram_if)
  );

  // Behavioural BRAM: read returns the pre-write word on a same-address hit.
  logic [DW-1:0] mem [2**AW];

  always @(posedge bram_if.clk) begin
    if (bram_if.rst_n && bram_if.en_a) begin
      if (bram_if.we_a) mem[bram_if.addr_a] <= bram_if.data_in_a;
      else              bram_if.data_out_a  <= mem[bram_if.addr_a];
    end
    if (bram_if.rst_n && bram_if.en_b && bram_if.we_b) begin
      mem[bram_if.addr_b] <= bram_if.data_in_b;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_pool;

    rst          = 1'b1;
    conv_rd_req  = 1'b0;
    conv_rd_addr = '0;
    conv_wr_req  = 1'b0;
    conv_wr_addr = '0;
    conv_wr_data = '0;
    pool_rd_req  = 1'b0;
    pool_rd_addr = '0;
    bram_if.data_out_a = '0;
    for (int i = 0; i < 2**AW; i++) mem[i] = '0;
    mem[10'h005] = 16'h1234;
    mem[10'h010] = 16'h00AA;
    mem[10'h020] = 16'h1111;
    mem[10'h050] = 16'h0BEE;

    // ---- Reset: requests asserted, everything must stay quiet
    tick();
    tick();
    conv_rd_req = 1'b1;
    pool_rd_req = 1'b1;
    conv_wr_req = 1'b1;
    #1;
    check("rst_conv_rd_gnt", conv_rd_gnt, 0);
    check("rst_pool_rd_gnt", pool_rd_gnt, 0);
    check("rst_conv_wr_gnt", conv_wr_gnt, 0);
    check("rst_conv_valid", conv_rd_valid, 0);
    check("rst_pool_valid", pool_rd_valid, 0);
    check("rst_conv_data", conv_rd_data, 0);
    check("rst_pool_data", pool_rd_data, 0);
    check("rst_en_a", bram_if.en_a, 0);
    check("rst_en_b", bram_if.en_b, 0);
    check("rst_we_b", bram_if.we_b, 0);
    tick();
    conv_rd_req = 1'b0;
    pool_rd_req = 1'b0;
    conv_wr_req = 1'b0;
    rst = 1'b0;

    // ---- First conv read of 0x005
    tick();
    conv_rd_req  = 1'b1;
    conv_rd_addr = 10'h005;
    #1;
    check("rd1_gnt", conv_rd_gnt, 1);
    check("rd1_pool_gnt", pool_rd_gnt, 0);
    check("rd1_addr_a", bram_if.addr_a, 10'h005);
    tick();
    conv_rd_req = 1'b0;
    #1;
    check("rd1_valid", conv_rd_valid, 1);
    check("rd1_data", conv_rd_data, 16'h1234);
    check("rd1_pool_valid", pool_rd_valid, 0);

    // ---- Both clients request continuously; pointer now favours pool
    conv_rd_req  = 1'b1;
    conv_rd_addr = 10'h005;
    pool_rd_req  = 1'b1;
    pool_rd_addr = 10'h030;
    exp_pool     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("alt_conv_gnt", conv_rd_gnt, {31'd0, !exp_pool});
      check("alt_pool_gnt", pool_rd_gnt, {31'd0, exp_pool});
      tick();
      check("alt_conv_valid", conv_rd_valid, {31'd0, !exp_pool});
      check("alt_pool_valid", pool_rd_valid, {31'd0, exp_pool});
      if (exp_pool) check("alt_pool_data", pool_rd_data, 16'h0000);
      else          check("alt_conv_data", conv_rd_data, 16'h1234);
      exp_pool = !exp_pool;
    end
    conv_rd_req = 1'b0;
    pool_rd_req = 1'b0;

    // ---- Pool read-and-clear of 0x010
    tick();
    pool_rd_req  = 1'b1;
    pool_rd_addr = 10'h010;
    #1;
    check("clr_pool_gnt", pool_rd_gnt, 1);
    check("clr_addr_a", bram_if.addr_a, 10'h010);
    tick();
    pool_rd_req = 1'b0;
    #1;
    check("clr_pool_valid", pool_rd_valid, 1);
    check("clr_pool_data", pool_rd_data, 16'h00AA);
    check("clr_en_b", bram_if.en_b, 1);
    check("clr_we_b", bram_if.we_b, 1);
    check("clr_addr_b", bram_if.addr_b, 10'h010);
    check("clr_data_b", bram_if.data_in_b, 0);
    tick();
    pool_rd_req = 1'b1;
    #1;
    check("clr_reread_gnt", pool_rd_gnt, 1);
    tick();
    pool_rd_req = 1'b0;
    #1;
    check("clr_reread_data", pool_rd_data, 0);

    // ---- Clear blocks a conv write for one cycle
    tick();
    pool_rd_req  = 1'b1;
    pool_rd_addr = 10'h040;
    #1;
    check("stall_pool_gnt", pool_rd_gnt, 1);
    tick();
    pool_rd_req  = 1'b0;
    conv_wr_req  = 1'b1;
    conv_wr_addr = 10'h040;
    conv_wr_data = 16'h5555;
    #1;
    check("stall_wr_gnt0", conv_wr_gnt, 0);
    check("stall_addr_b", bram_if.addr_b, 10'h040);
    check("stall_clr_data", bram_if.data_in_b, 0);
    tick();
    check("stall_wr_gnt1", conv_wr_gnt, 1);
    check("stall_wr_data_b", bram_if.data_in_b, 16'h5555);
    tick();
    conv_wr_req  = 1'b0;
    conv_rd_req  = 1'b1;
    conv_rd_addr = 10'h040;
    #1;
    check("stall_rd_gnt", conv_rd_gnt, 1);
    tick();
    conv_rd_req = 1'b0;
    #1;
    check("stall_rd_data", conv_rd_data, 16'h5555);
    check("stall_mem", mem[10'h040], 16'h5555);
`ifdef CONV_BRAM_ARB_STATS_EN
    check("stat_stall_pre", stat_wr_stall, 1);
    check("stat_fwd_pre", stat_fwd, 0);
`endif

    // ---- Reset pulse, then forwarding: pool read + conv write of 0x020
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    pool_rd_req  = 1'b1;
    pool_rd_addr = 10'h020;
    conv_wr_req  = 1'b1;
    conv_wr_addr = 10'h020;
    conv_wr_data = 16'h7777;
    #1;
    check("fwd_pool_gnt", pool_rd_gnt, 1);
    check("fwd_wr_gnt", conv_wr_gnt, 1);
    tick();
    pool_rd_req = 1'b0;
    conv_wr_req = 1'b0;
    #1;
    check("fwd_pool_valid", pool_rd_valid, 1);
    check("fwd_pool_data", pool_rd_data, 16'h7777);
    check("fwd_clr_addr_b", bram_if.addr_b, 10'h020);
    check("fwd_clr_data_b", bram_if.data_in_b, 0);
`ifdef CONV_BRAM_ARB_STATS_EN
    check("stat_fwd", stat_fwd, 1);
`endif
    tick();
    conv_rd_req  = 1'b1;
    conv_rd_addr = 10'h020;
    #1;
    check("fwd_rd_gnt", conv_rd_gnt, 1);
    tick();
    conv_rd_req = 1'b0;
    #1;
    check("fwd_cleared", conv_rd_data, 0);

    // ---- Reset mid-stream with a pending clear (pointer favours pool here)
    conv_rd_req  = 1'b1;
    conv_rd_addr = 10'h005;
    pool_rd_req  = 1'b1;
    pool_rd_addr = 10'h050;
    #1;
    check("mrst_pool_gnt", pool_rd_gnt, 1);
    check("mrst_conv_gnt0", conv_rd_gnt, 0);
    tick();
    check("mrst_conv_gnt1", conv_rd_gnt, 1);
    check("mrst_pool_valid", pool_rd_valid, 1);
    check("mrst_pool_data", pool_rd_data, 16'h0BEE);
    check("mrst_en_b", bram_if.en_b, 1);
    check("mrst_addr_b", bram_if.addr_b, 10'h050);
    rst = 1'b1;
    #1;
    check("mrst_en_b_drop", bram_if.en_b, 0);
    check("mrst_we_b_drop", bram_if.we_b, 0);
    check("mrst_en_a_drop", bram_if.en_a, 0);
    check("mrst_conv_gnt_drop", conv_rd_gnt, 0);
    check("mrst_pool_valid_drop", pool_rd_valid, 0);
    check("mrst_pool_data_zero", pool_rd_data, 0);
    tick();
    rst = 1'b0;
    #1;
    check("mrst_ptr_conv", conv_rd_gnt, 1);
    check("mrst_ptr_pool", pool_rd_gnt, 0);
    check("mrst_mem_kept", mem[10'h050], 16'h0BEE);
    conv_rd_req = 1'b0;
    pool_rd_req = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_conv_bram_arbiter
